leaf_bft_packet_tx: RTL and testbench
=====================================

// Module: leaf_bft_packet_tx
// PURPOSE
//  Transmit end of the leaf<->BFT packet link. Collects the user kernel's 32-bit vld/ack output streams,
//  stamps each word with a configured destination (leaf, port) and a rolling BRAM address, and issues one
//  49-bit packet per cycle toward the BFT. Per-output credits model receiver BRAM free space.
//  Config and freespace-update packets arrive on the inbound BFT bus.
// PARAMETERS
//  PACKET_BITS           49   packet width: {valid[48], leaf[47:43], port[42:39], addr[38:32], payload[31:0]}
//  PAYLOAD_BITS          32   user data width
//  NUM_LEAF_BITS         5    destination leaf field width
//  NUM_PORT_BITS         4    destination port field width
//  NUM_ADDR_BITS         7    BRAM address field width; max credits = 2**NUM_ADDR_BITS
//  NUM_OUT_PORTS         4    user output streams, 1..15
//  FREESPACE_UPDATE_SIZE 64   credits returned per freespace-update packet
// PORTS
//  clk                  in   1                          system clock (400 MHz domain)
//  reset                in   1                          synchronous, active-high
//  din_leaf_bft2interface   in   PACKET_BITS           inbound config / freespace-update packets
//  dout_leaf_interface2bft  out  PACKET_BITS           outbound packets; bit 48 = valid
//  resend               in   1                          stall: no grants; dout forced to 0
//  din_leaf_user2interface  in   NUM_OUT_PORTS*32      user data, output i at [32i+31:32i]
//  vld_user2interface   in   NUM_OUT_PORTS            user word valid per output
//  ack_interface2user   out  NUM_OUT_PORTS            word accepted this cycle (one-hot or zero)
// BEHAVIOUR
//  Reset: dout = 0; ack = 0; all dest regs = 0; all addr ctrs = 0; credits = 2**NUM_ADDR_BITS; RR ptr = 0.
//  Eligible(i) = vld[i] & credit[i] != 0 & dest_valid[i] & !resend.
//  Arbitration: round robin starting at rr_ptr; at most one grant per cycle; ack[i] is combinational in the
//   grant cycle. After a grant to i, rr_ptr = i+1 (mod NUM_OUT_PORTS). No grant leaves rr_ptr unchanged.
//  Transfer: vld & ack in the same cycle = one word; user holds data/vld stable until ack.
//  Output: registered, 1-cycle latency: dout = {1'b1, dest_leaf[i], dest_port[i], addr[i], data_i}.
//   dout = 0 in any cycle with no grant. resend = 1 forces dout = 0 and ack = 0; no state advances.
//  addr[i] increments per grant and wraps 127 -> 0. credit[i] decrements per grant.
//  Inbound decode (valid bit 48 set; other packets ignored):
//   port field == 0: config. payload[31:28] = output idx, dest_leaf <= payload[8:4],
//    dest_port <= payload[3:0], dest_valid <= 1. Idx >= NUM_OUT_PORTS is ignored.
//   port field == 1: freespace update. payload[3:0] = output idx, credit += FREESPACE_UPDATE_SIZE,
//    saturating at 2**NUM_ADDR_BITS. Bad idx is ignored.
//  Simultaneous grant + update on the same output: credit' = min(credit - 1 + SIZE, 2**NUM_ADDR_BITS).
//  Config on an output granted in the same cycle: the granted packet uses the old dest; the new dest
//   applies from the next grant.
//  Credit 0: output is skipped by the arbiter and ack stays 0 until an update arrives.
//  Reset mid-stream: the in-flight registered packet is dropped (dout = 0 next cycle) and all state is
//   reinitialised.
// CONFIGURATION
//  LEAF_BFT_TX_STATS_EN defined: adds output tx_pkt_count [NUM_OUT_PORTS*32] (per-output granted packets,
//   wrapping) and output tx_stall_count [32]. tx_stall_count counts cycles where some vld=1 but there
//   was no grant. Both reset to 0.
//  Not defined: these ports and their counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package leaf_pkt_pkg:
//   - field offsets/widths for valid, leaf, port, addr, payload
//   - CFG_PORT = 0 and FREESPACE_PORT = 1 constants
//   - function pack_pkt(leaf, port, addr, data)
//  One sub-module, rr_arbiter #(N) (req, en -> one-hot grant, ptr update). Credits, addr and dest are
//   kept inline.
// TESTING
//  1. Reset; cfg out0 -> leaf 3 port 2; vld0 = 1, data 0xDEADBEEF -> ack0 in cycle t;
//     dout at t+1 = {1,5'd3,4'd2,7'd0,32'hDEADBEEF}.
//  2. Outputs 0..3 configured, all vld held high -> grants 0,1,2,3,0,... one per cycle; addr per output
//     increments independently.
//  3. Out1 streams 128 words with no update -> ack1 = 0 from word 129; one freespace update idx 1
//     -> 64 more words accepted.
//  4. Out2 sends 130 words with updates -> addr field of word 129 is 0 (wrap).
//  5. resend = 1 for 3 cycles mid-stream -> dout = 0 and ack = 0 for those cycles; the stream resumes
//     with no lost or duplicated addr.
//  6. Credit at 128 plus an update -> credit stays 128; an unconfigured output with vld = 1 never
//     receives ack.

Source files
------------

// File: rtl/leaf_pkt_pkg.sv
// ---------------------------------------------------------------------------
// leaf_pkt_pkg
// Shared definitions for the leaf<->BFT packet link.
// Packet layout (49 bits):
//   {valid[48], leaf[47:43], port[42:39], addr[38:32], payload[31:0]}
// Contents: field widths/offsets, the two inbound control port numbers
// (config and freespace update), credit limits, field typedefs and the
// pack_pkt() helper that builds a valid outbound packet.
// ---------------------------------------------------------------------------
package leaf_pkt_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;

  localparam int VALID_BIT             = 48;
  localparam int LEAF_LSB              = 43;
  localparam int PORT_LSB              = 39;
  localparam int ADDR_LSB              = 32;
  localparam int PAYLOAD_LSB           = 0;

  localparam int MAX_CREDITS           = 2 ** NUM_ADDR_BITS;
  localparam int CREDIT_BITS           = NUM_ADDR_BITS + 1;
  localparam int FREESPACE_UPDATE_SIZE = 64;

  localparam logic [NUM_PORT_BITS-1:0] CFG_PORT       = 4'd0;
  localparam logic [NUM_PORT_BITS-1:0] FREESPACE_PORT = 4'd1;

  typedef logic [PACKET_BITS-1:0]   packet_t;
  typedef logic [NUM_LEAF_BITS-1:0] leaf_t;
  typedef logic [NUM_PORT_BITS-1:0] port_t;
  typedef logic [NUM_ADDR_BITS-1:0] addr_t;
  typedef logic [PAYLOAD_BITS-1:0]  payload_t;
  typedef logic [CREDIT_BITS-1:0]   credit_t;

  // Builds a valid packet from its fields using the shared offsets.
  function automatic packet_t pack_pkt(leaf_t leaf, port_t port, addr_t addr, payload_t data);
    packet_t p;
    p = '0;
    p[VALID_BIT]                         = 1'b1;
    p[LEAF_LSB +: NUM_LEAF_BITS]         = leaf;
    p[PORT_LSB +: NUM_PORT_BITS]         = port;
    p[ADDR_LSB +: NUM_ADDR_BITS]         = addr;
    p[PAYLOAD_LSB +: PAYLOAD_BITS]       = data;
    return p;
  endfunction

endpackage

// File: rtl/leaf_bft_packet_tx_if.sv
// ---------------------------------------------------------------------------
// leaf_bft_packet_tx_if
// Bundles the BFT-side and user-side signals of the packet transmitter.
//   din_leaf_bft2interface   inbound config / freespace-update packets
//   dout_leaf_interface2bft  outbound packets (bit 48 = valid)
//   resend                   stall request from the BFT
//   din_leaf_user2interface  user data, output i at [32i+31:32i]
//   vld_user2interface       per-output word valid
//   ack_interface2user       per-output word accepted (one-hot or zero)
// Modports: slave = transmitter, master = environment (user + BFT).
// ---------------------------------------------------------------------------
interface leaf_bft_packet_tx_if #(
  parameter int NUM_OUT_PORTS = 4
);
  import leaf_pkt_pkg::*;

  packet_t                               din_leaf_bft2interface;
  packet_t                               dout_leaf_interface2bft;
  logic                                  resend;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

  modport slave (
    input  din_leaf_bft2interface,
    input  resend,
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output dout_leaf_interface2bft,
    output ack_interface2user
  );

  modport master (
    output din_leaf_bft2interface,
    output resend,
    output din_leaf_user2interface,
    output vld_user2interface,
    input  dout_leaf_interface2bft,
    input  ack_interface2user
  );

endinterface

// File: rtl/leaf_bft_packet_tx_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: at most one grant per cycle, searching from the
// pointer. After a grant to i the pointer moves to i+1 (mod N); with no
// grant it holds.
// Ports:
//   clk, reset   clock, synchronous active-high reset (pointer -> 0)
//   req_i        request vector
//   en_i         when low nothing is granted and the pointer holds
//   grant_o      one-hot grant (combinational)
//   grant_vld_o  a grant was issued this cycle
//   grant_idx_o  index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     grant_o,
  output logic             grant_vld_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand;

  // Walk the requesters in rotated order starting at the pointer and take
  // the first one that is asking.
  always_comb begin
    grant_o     = '0;
    grant_vld_o = 1'b0;
    grant_idx_o = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N);
      if (en_i && !grant_vld_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_vld_o   = 1'b1;
        grant_idx_o   = cand;
      end
    end
    ptr_d = grant_vld_o ? IDX_W'((int'(grant_idx_o) + 1) % N) : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/leaf_bft_packet_tx.sv
// ---------------------------------------------------------------------------
// leaf_bft_packet_tx
// Transmit end of the leaf<->BFT packet link. Arbitrates the user output
// streams round robin, stamps the granted word with its configured
// destination (leaf, port) and rolling BRAM address, and registers one
// packet per cycle toward the BFT. Per-output credits track receiver BRAM
// free space; config and freespace-update packets arrive on the inbound bus.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          leaf_bft_packet_tx_if.slave (BFT in/out, user data/vld/ack)
// Optional (macro LEAF_BFT_TX_STATS_EN):
//   tx_pkt_count    per-output granted packet counters, 32 bits each
//   tx_stall_count  cycles with some vld high but no grant
// ---------------------------------------------------------------------------
module leaf_bft_packet_tx
  import leaf_pkt_pkg::*;
#(
  parameter  int NUM_OUT_PORTS = 4,
  localparam int IDX_W         = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  leaf_bft_packet_tx_if.slave         bus
`ifdef LEAF_BFT_TX_STATS_EN
  ,
  output logic [NUM_OUT_PORTS*32-1:0] tx_pkt_count,
  output logic [31:0]                 tx_stall_count
`endif
);

  leaf_t                    destLeaf_q [NUM_OUT_PORTS];
  leaf_t                    destLeaf_d [NUM_OUT_PORTS];
  port_t                    destPort_q [NUM_OUT_PORTS];
  port_t                    destPort_d [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] destValid_q, destValid_d;
  addr_t                    addr_q [NUM_OUT_PORTS];
  addr_t                    addr_d [NUM_OUT_PORTS];
  credit_t                  credit_q [NUM_OUT_PORTS];
  credit_t                  credit_d [NUM_OUT_PORTS];
  packet_t                  dout_q, dout_d;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic                     grantVld;
  logic [IDX_W-1:0]         grantIdx;
  logic                     arbEn;

  logic                     inValid;
  port_t                    inPort;
  payload_t                 inPayload;
  logic                     cfgHit, fsHit;
  logic [3:0]               cfgIdx, fsIdx;
  logic                     unusedInBits;

  // Inbound decode: only the port field and a few payload bits matter.
  assign inValid      = bus.din_leaf_bft2interface[VALID_BIT];
  assign inPort       = bus.din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign inPayload    = bus.din_leaf_bft2interface[PAYLOAD_LSB +: PAYLOAD_BITS];
  assign cfgHit       = inValid && (inPort == CFG_PORT);
  assign fsHit        = inValid && (inPort == FREESPACE_PORT);
  assign cfgIdx       = inPayload[31:28];
  assign fsIdx        = inPayload[3:0];
  assign unusedInBits = ^{bus.din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS],
                          bus.din_leaf_bft2interface[ADDR_LSB +: NUM_ADDR_BITS],
                          inPayload[27:9]};

  // An output may compete only with a word, a credit and a destination.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = bus.vld_user2interface[i] && (credit_q[i] != '0) && destValid_q[i];
    end
  end

  // Reset also blocks grants so no word is acked while state is cleared.
  assign arbEn = !bus.resend && !reset;

  rr_arbiter #(.N(NUM_OUT_PORTS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (eligible),
    .en_i        (arbEn),
    .grant_o     (grant),
    .grant_vld_o (grantVld),
    .grant_idx_o (grantIdx)
  );

  assign bus.ack_interface2user      = grant;
  assign bus.dout_leaf_interface2bft = dout_q;

  // Credit after this cycle: a grant spends one, an update returns a block,
  // and the result never exceeds the receiver BRAM depth.
  function automatic credit_t nextCredit(credit_t cur, logic dec, logic inc);
    int sum;
    sum = int'(cur) - int'(dec) + (inc ? FREESPACE_UPDATE_SIZE : 0);
    if (sum > MAX_CREDITS) sum = MAX_CREDITS;
    return credit_t'(sum);
  endfunction

  // Next-state logic. The outgoing packet is built from the current
  // destination registers, so a config landing in the grant cycle only
  // affects later grants.
  always_comb begin
    dout_d      = '0;
    destValid_d = destValid_q;
    if (grantVld) begin
      dout_d = pack_pkt(destLeaf_q[grantIdx], destPort_q[grantIdx], addr_q[grantIdx],
                        bus.din_leaf_user2interface[int'(grantIdx)*PAYLOAD_BITS +: PAYLOAD_BITS]);
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      addr_d[i]     = addr_q[i] + addr_t'(grant[i]);
      credit_d[i]   = nextCredit(credit_q[i], grant[i], fsHit && (fsIdx == 4'(i)));
      destLeaf_d[i] = destLeaf_q[i];
      destPort_d[i] = destPort_q[i];
      if (cfgHit && (cfgIdx == 4'(i))) begin
        destLeaf_d[i]  = inPayload[8:4];
        destPort_d[i]  = inPayload[3:0];
        destValid_d[i] = 1'b1;
      end
    end
  end

  // State registers; reset drops any packet still in the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q      <= '0;
      destValid_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        destLeaf_q[i] <= '0;
        destPort_q[i] <= '0;
        addr_q[i]     <= '0;
        credit_q[i]   <= credit_t'(MAX_CREDITS);
      end
    end else begin
      dout_q      <= dout_d;
      destValid_q <= destValid_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        destLeaf_q[i] <= destLeaf_d[i];
        destPort_q[i] <= destPort_d[i];
        addr_q[i]     <= addr_d[i];
        credit_q[i]   <= credit_d[i];
      end
    end
  end

`ifdef LEAF_BFT_TX_STATS_EN
  logic [31:0] pktCount_q [NUM_OUT_PORTS];
  logic [31:0] stallCount_q;

  // Statistics: wrapping per-output grant counters and a stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) pktCount_q[i] <= '0;
    end else begin
      if ((|bus.vld_user2interface) && !grantVld) stallCount_q <= stallCount_q + 32'd1;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (grant[i]) pktCount_q[i] <= pktCount_q[i] + 32'd1;
      end
    end
  end

  // Flatten the per-output counters onto the output bus.
  always_comb begin
    tx_pkt_count = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) tx_pkt_count[i*32 +: 32] = pktCount_q[i];
  end

  assign tx_stall_count = stallCount_q;
`endif

endmodule

// File: tb/tb_leaf_bft_packet_tx.sv
// ---------------------------------------------------------------------------
// tb_leaf_bft_packet_tx
// Self-checking bench for leaf_bft_packet_tx with a behavioural reference
// model (per-output credit/address/destination arrays, round-robin pointer).
// ---------------------------------------------------------------------------
module tb_leaf_bft_packet_tx;
  import leaf_pkt_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  // Free-running clock.
  always #5 clk = ~clk;

  leaf_bft_packet_tx_if #(.NUM_OUT_PORTS(N)) bus ();

`ifdef LEAF_BFT_TX_STATS_EN
  logic [N*32-1:0] txPktCount;
  logic [31:0]     txStallCount;
`endif

  leaf_bft_packet_tx #(.NUM_OUT_PORTS(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus)
`ifdef LEAF_BFT_TX_STATS_EN
    ,
    .tx_pkt_count   (txPktCount),
    .tx_stall_count (txStallCount)
`endif
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [N-1:0]  vldReg;
  logic [31:0]   dataReg [N];
  logic          resendReg;
  logic [48:0]   bftReg;

  int            mCredit [N];
  int            mAddr   [N];
  logic [4:0]    mLeaf   [N];
  logic [3:0]    mPort   [N];
  bit            mValid  [N];
  int            mPtr;
  logic [48:0]   mDout;

  function automatic logic [48:0] cfgPkt(input int idx, input int leaf, input int port);
    logic [3:0] i4;
    logic [4:0] l5;
    logic [3:0] p4;
    i4 = 4'(idx);
    l5 = 5'(leaf);
    p4 = 4'(port);
    return {1'b1, 5'd0, 4'd0, 7'd0, i4, 19'd0, l5, p4};
  endfunction

  function automatic logic [48:0] updPkt(input int idx);
    logic [3:0] i4;
    i4 = 4'(idx);
    return {1'b1, 5'd0, 4'd1, 7'd0, 28'd0, i4};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mCredit[i] = 128;
      mAddr[i]   = 0;
      mLeaf[i]   = '0;
      mPort[i]   = '0;
      mValid[i]  = 1'b0;
    end
    mPtr  = 0;
    mDout = '0;
  endtask

  // One clock cycle: drive inputs, sample outputs before the rising edge,
  // advance the reference model, then move to the next falling edge.
  task automatic applyStimulus(output logic [N-1:0] gotAck, output logic [N-1:0] expAck,
                               output logic [48:0] gotDout, output logic [48:0] expDout);
    int g;
    int idx;
    int ptype;
    bus.vld_user2interface     = vldReg;
    bus.resend                 = resendReg;
    bus.din_leaf_bft2interface = bftReg;
    for (int i = 0; i < N; i++) bus.din_leaf_user2interface[i*32 +: 32] = dataReg[i];
    #1;
    gotAck  = bus.ack_interface2user;
    gotDout = bus.dout_leaf_interface2bft;
    expDout = mDout;
    g = -1;
    if (!reset && !resendReg) begin
      for (int k = 0; k < N; k++) begin
        idx = (mPtr + k) % N;
        if (g < 0 && vldReg[idx] && mCredit[idx] > 0 && mValid[idx]) g = idx;
      end
    end
    expAck = '0;
    if (g >= 0) expAck[g] = 1'b1;
    if (reset) begin
      modelReset();
    end else begin
      if (g >= 0) begin
        mDout      = {1'b1, mLeaf[g], mPort[g], 7'(mAddr[g]), dataReg[g]};
        mAddr[g]   = (mAddr[g] + 1) % 128;
        mCredit[g] = mCredit[g] - 1;
        mPtr       = (g + 1) % N;
      end else begin
        mDout = '0;
      end
      if (bftReg[48]) begin
        ptype = int'(bftReg[42:39]);
        if (ptype == 0) begin
          idx = int'(bftReg[31:28]);
          if (idx < N) begin
            mLeaf[idx]  = bftReg[8:4];
            mPort[idx]  = bftReg[3:0];
            mValid[idx] = 1'b1;
          end
        end else if (ptype == 1) begin
          idx = int'(bftReg[3:0]);
          if (idx < N) mCredit[idx] = (mCredit[idx] + 64 > 128) ? 128 : mCredit[idx] + 64;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    logic [N-1:0] a, e;
    logic [48:0]  d, f;
    reset     = 1'b1;
    vldReg    = '0;
    resendReg = 1'b0;
    bftReg    = '0;
    applyStimulus(a, e, d, f);
    applyStimulus(a, e, d, f);
    reset = 1'b0;
  endtask

  task automatic sendPkt(input logic [48:0] pkt);
    logic [N-1:0] a, e;
    logic [48:0]  d, f;
    bftReg = pkt;
    applyStimulus(a, e, d, f);
    bftReg = '0;
  endtask

  task automatic test_reset();
    logic [N-1:0] gA, eA;
    logic [48:0]  gD, eD;
    doReset();
    vldReg = '1;
    for (int i = 0; i < N; i++) dataReg[i] = $urandom;
    applyStimulus(gA, eA, gD, eD);
    testsRun++;
    if (gA !== '0) begin testsFailed++; $display("[TB] FAIL reset_ack: got %b expected 0", gA); end
    testsRun++;
    if (gD !== '0) begin testsFailed++; $display("[TB] FAIL reset_dout: got %h expected 0", gD); end
    vldReg = '0;
  endtask

  task automatic test_single_word();
    logic [N-1:0] gA, eA;
    logic [48:0]  gD, eD;
    doReset();
    sendPkt(cfgPkt(0, 3, 2));
    vldReg     = 4'b0001;
    dataReg[0] = 32'hDEADBEEF;
    applyStimulus(gA, eA, gD, eD);
    testsRun++;
    if (gA !== 4'b0001) begin testsFailed++; $display("[TB] FAIL single_ack: got %b expected 0001", gA); end
    vldReg = '0;
    applyStimulus(gA, eA, gD, eD);
    testsRun++;
    if (gD !== {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}) begin
      testsFailed++;
      $display("[TB] FAIL single_dout: got %h expected %h", gD, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] gA, eA;
    logic [48:0]  gD, eD;
    logic [N-1:0] want;
    doReset();
    for (int i = 0; i < N; i++) sendPkt(cfgPkt(i, $urandom_range(0, 31), $urandom_range(0, 15)));
    vldReg = '1;
    for (int i = 0; i < N; i++) dataReg[i] = $urandom;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(gA, eA, gD, eD);
      want = 4'(1 << (k % 4));
      testsRun++;
      if (gA !== want) begin testsFailed++; $display("[TB] FAIL rr_ack[%0d]: got %b expected %b", k, gA, want); end
      testsRun++;
      if (gD !== eD) begin testsFailed++; $display("[TB] FAIL rr_dout[%0d]: got %h expected %h", k, gD, eD); end
      if (k > 0) begin
        testsRun++;
        if (gD[38:32] !== 7'((k - 1) / 4)) begin
          testsFailed++;
          $display("[TB] FAIL rr_addr[%0d]: got %0d expected %0d", k, gD[38:32], (k - 1) / 4);
        end
      end
      for (int i = 0; i < N; i++) if (gA[i]) dataReg[i] = $urandom;
    end
    vldReg = '0;
    applyStimulus(gA, eA, gD, eD);
    testsRun++;
    if (gD !== eD) begin testsFailed++; $display("[TB] FAIL rr_last_dout: got %h expected %h", gD, eD); end
  endtask

  task automatic test_credit_exhaust();
    logic [N-1:0] gA, eA;
    logic [48:0]  gD, eD;
    int count;
    doReset();
    sendPkt(cfgPkt(1, 7, 9));
    vldReg     = 4'b0010;
    dataReg[1] = $urandom;
    count      = 0;
    for (int c = 0; c < 140; c++) begin
      applyStimulus(gA, eA, gD, eD);
      testsRun++;
      if (gA !== eA || gD !== eD) begin
        testsFailed++;
        $display("[TB] FAIL credit_cycle[%0d]: ack %b/%b dout %h/%h (got/expected)", c, gA, eA, gD, eD);
      end
      if (gA[1]) begin count++; dataReg[1] = $urandom; end
    end
    testsRun++;
    if (count != 128) begin testsFailed++; $display("[TB] FAIL credit_words: got %0d expected 128", count); end
    testsRun++;
    if (gA !== '0) begin testsFailed++; $display("[TB] FAIL credit_zero_ack: got %b expected 0", gA); end
    sendPkt(updPkt(1));
    count = 0;
    for (int c = 0; c < 80; c++) begin
      applyStimulus(gA, eA, gD, eD);
      if (gA[1]) begin count++; dataReg[1] = $urandom; end
    end
    testsRun++;
    if (count != 64) begin testsFailed++; $display("[TB] FAIL credit_refill_words: got %0d expected 64", count); end
    vldReg = '0;
  endtask

  task automatic test_addr_wrap();
    logic [N-1:0] gA, eA;
    logic [48:0]  gD, eD;
    logic [6:0]   addrs [$];
    int words;
    doReset();
    sendPkt(cfgPkt(2, 17, 4));
    vldReg     = 4'b0100;
    dataReg[2] = $urandom;
    words      = 0;
    for (int c = 0; c < 140; c++) begin
      bftReg = (c == 60) ? updPkt(2) : '0;
      applyStimulus(gA, eA, gD, eD);
      testsRun++;
      if (gA !== eA || gD !== eD) begin
        testsFailed++;
        $display("[TB] FAIL wrap_cycle[%0d]: ack %b/%b dout %h/%h (got/expected)", c, gA, eA, gD, eD);
      end
      if (gD[48]) addrs.push_back(gD[38:32]);
      if (gA[2]) begin
        words++;
        dataReg[2] = $urandom;
        if (words == 130) vldReg = '0;
      end
    end
    bftReg = '0;
    testsRun++;
    if (addrs.size() != 130) begin
      testsFailed++;
      $display("[TB] FAIL wrap_count: got %0d expected 130", addrs.size());
    end else begin
      testsRun++;
      if (addrs[127] !== 7'd127) begin testsFailed++; $display("[TB] FAIL wrap_addr127: got %0d expected 127", addrs[127]); end
      testsRun++;
      if (addrs[128] !== 7'd0) begin testsFailed++; $display("[TB] FAIL wrap_addr128: got %0d expected 0", addrs[128]); end
      testsRun++;
      if (addrs[129] !== 7'd1) begin testsFailed++; $display("[TB] FAIL wrap_addr129: got %0d expected 1", addrs[129]); end
    end
  endtask

  task automatic test_resend();
    logic [N-1:0] gA, eA;
    logic [48:0]  gD, eD;
    int nextAddr [2];
    int acks;
    int o;
    doReset();
    sendPkt(cfgPkt(0, 1, 5));
    sendPkt(cfgPkt(1, 2, 6));
    vldReg      = 4'b0011;
    dataReg[0]  = $urandom;
    dataReg[1]  = $urandom;
    nextAddr[0] = 0;
    nextAddr[1] = 0;
    acks        = 0;
    for (int c = 0; c < 21; c++) begin
      resendReg = (c >= 5 && c <= 7);
      if (c == 20) vldReg = '0;
      applyStimulus(gA, eA, gD, eD);
      if (c >= 5 && c <= 7) begin
        testsRun++;
        if (gA !== '0) begin testsFailed++; $display("[TB] FAIL resend_ack[%0d]: got %b expected 0", c, gA); end
      end
      if (c >= 6 && c <= 8) begin
        testsRun++;
        if (gD !== '0) begin testsFailed++; $display("[TB] FAIL resend_dout[%0d]: got %h expected 0", c, gD); end
      end
      testsRun++;
      if (gA !== eA || gD !== eD) begin
        testsFailed++;
        $display("[TB] FAIL resend_cycle[%0d]: ack %b/%b dout %h/%h (got/expected)", c, gA, eA, gD, eD);
      end
      if (gD[48]) begin
        o = (gD[42:39] == 4'd5) ? 0 : 1;
        testsRun++;
        if (gD[38:32] !== 7'(nextAddr[o])) begin
          testsFailed++;
          $display("[TB] FAIL resend_addr_out%0d: got %0d expected %0d", o, gD[38:32], nextAddr[o]);
        end
        nextAddr[o]++;
      end
      for (int i = 0; i < 2; i++) if (gA[i]) begin acks++; dataReg[i] = $urandom; end
    end
    resendReg = 1'b0;
    testsRun++;
    if (nextAddr[0] + nextAddr[1] != acks) begin
      testsFailed++;
      $display("[TB] FAIL resend_pkt_count: got %0d expected %0d", nextAddr[0] + nextAddr[1], acks);
    end
  endtask

  task automatic test_saturate_unconfigured();
    logic [N-1:0] gA, eA;
    logic [48:0]  gD, eD;
    int count0;
    int count3;
    doReset();
    sendPkt(cfgPkt(0, 9, 3));
    sendPkt(updPkt(0));
    sendPkt(cfgPkt(11, 5, 5));
    sendPkt(updPkt(7));
    vldReg     = 4'b1001;
    dataReg[0] = $urandom;
    dataReg[3] = $urandom;
    count0     = 0;
    count3     = 0;
    for (int c = 0; c < 140; c++) begin
      applyStimulus(gA, eA, gD, eD);
      if (gA[0]) begin count0++; dataReg[0] = $urandom; end
      if (gA[3]) count3++;
    end
    testsRun++;
    if (count0 != 128) begin testsFailed++; $display("[TB] FAIL sat_words: got %0d expected 128", count0); end
    testsRun++;
    if (count3 != 0) begin testsFailed++; $display("[TB] FAIL unconfigured_acks: got %0d expected 0", count3); end
    vldReg = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] gA, eA;
    logic [48:0]  gD, eD;
    int sel;
    doReset();
    for (int i = 0; i < N; i++) sendPkt(cfgPkt(i, $urandom_range(0, 31), $urandom_range(0, 15)));
    for (int c = 0; c < 600; c++) begin
      resendReg = ($urandom_range(0, 15) == 0);
      bftReg    = '0;
      if (!resendReg && $urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 5);
        if (sel <= 2)      bftReg = updPkt($urandom_range(0, 5));
        else if (sel == 3) bftReg = cfgPkt($urandom_range(0, 5), $urandom_range(0, 31), $urandom_range(0, 15));
        else if (sel == 4) bftReg = {1'b0, 48'($urandom), 1'b0} >> 1;
        else               bftReg = {1'b1, 5'd0, 4'd3, 7'd0, 32'($urandom)};
      end
      for (int i = 0; i < N; i++) begin
        if (!vldReg[i]) begin
          vldReg[i]  = 1'($urandom_range(0, 1));
          dataReg[i] = $urandom;
        end
      end
      applyStimulus(gA, eA, gD, eD);
      testsRun++;
      if (gA !== eA) begin testsFailed++; $display("[TB] FAIL random_ack[%0d]: got %b expected %b", c, gA, eA); end
      testsRun++;
      if (gD !== eD) begin testsFailed++; $display("[TB] FAIL random_dout[%0d]: got %h expected %h", c, gD, eD); end
      for (int i = 0; i < N; i++) if (gA[i]) vldReg[i] = 1'b0;
    end
    resendReg = 1'b0;
    bftReg    = '0;
    vldReg    = '0;
  endtask

  task automatic test_reset_midstream();
    logic [N-1:0] gA, eA;
    logic [48:0]  gD, eD;
    doReset();
    sendPkt(cfgPkt(0, 1, 1));
    vldReg     = 4'b0001;
    dataReg[0] = $urandom;
    applyStimulus(gA, eA, gD, eD);
    testsRun++;
    if (gA !== 4'b0001) begin testsFailed++; $display("[TB] FAIL midreset_grant: got %b expected 0001", gA); end
    reset = 1'b1;
    applyStimulus(gA, eA, gD, eD);
    testsRun++;
    if (gA !== '0) begin testsFailed++; $display("[TB] FAIL midreset_ack: got %b expected 0", gA); end
    testsRun++;
    if (gD !== eD) begin testsFailed++; $display("[TB] FAIL midreset_inflight: got %h expected %h", gD, eD); end
    reset = 1'b0;
    applyStimulus(gA, eA, gD, eD);
    testsRun++;
    if (gD !== '0) begin testsFailed++; $display("[TB] FAIL midreset_dropped: got %h expected 0", gD); end
    testsRun++;
    if (gA !== '0) begin testsFailed++; $display("[TB] FAIL midreset_unconfigured: got %b expected 0", gA); end
    vldReg = '0;
  endtask

  // Test sequence.
  initial begin
    reset     = 1'b1;
    vldReg    = '0;
    resendReg = 1'b0;
    bftReg    = '0;
    for (int i = 0; i < N; i++) dataReg[i] = '0;
    modelReset();
    @(negedge clk);
    test_reset();
    test_single_word();
    test_round_robin();
    test_credit_exhaust();
    test_addr_wrap();
    test_resend();
    test_saturate_unconfigured();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
